// File: rtl/mem_request_responder.sv
// Responder for the pipeline memory handshake: arbitrates data over instruction
// requests onto a single-ported RAM and returns one-cycle hit pulses with load data.
module mem_request_responder #(
  parameter int TIMEOUT = 64,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              memerr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               err_reg, err_next;
  logic               op_write_reg, op_write_next;
  logic               from_d_reg, from_d_next;
  logic [WORD_W-1:0]  addr_reg, addr_next;
  logic [WORD_W-1:0]  store_reg, store_next;
  logic [WORD_W-1:0]  iload_reg, iload_next;
  logic [WORD_W-1:0]  dload_reg, dload_next;

  logic ram_access;
  logic ram_fail;
  logic still_requested;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      op_write_reg <= 1'b0;
      from_d_reg   <= 1'b0;
      addr_reg     <= '0;
      store_reg    <= '0;
      iload_reg    <= '0;
      dload_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      op_write_reg <= op_write_next;
      from_d_reg   <= from_d_next;
      addr_reg     <= addr_next;
      store_reg    <= store_next;
      iload_reg    <= iload_next;
      dload_reg    <= dload_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    op_write_next = op_write_reg;
    from_d_next   = from_d_reg;
    addr_next     = addr_reg;
    store_next    = store_reg;
    iload_next    = iload_reg;
    dload_next    = dload_reg;

    ram_access      = (ramstate == RAM_ACCESS);
    ram_fail        = (ramstate == RAM_ERROR) || (cnt_reg == CNT_LAST);
    still_requested = (state_reg == SERVE_D) ? (dREN | dWEN) : iREN;

    case (state_reg)
      IDLE: begin
        if (dREN || dWEN) begin
          state_next    = SERVE_D;
          addr_next     = daddr;
          store_next    = dstore;
          op_write_next = dWEN;
          from_d_next   = 1'b1;
          cnt_next      = '0;
          err_next      = 1'b0;
        end else if (iREN) begin
          state_next    = SERVE_I;
          addr_next     = iaddr;
          op_write_next = 1'b0;
          from_d_next   = 1'b0;
          cnt_next      = '0;
          err_next      = 1'b0;
        end
      end

      SERVE_D, SERVE_I: begin
        // Completion outranks abort so a request dropped on the ACCESS cycle still hits.
        if (ram_access) begin
          state_next = DONE;
          if (state_reg == SERVE_I) begin
            iload_next = ramload;
          end else if (!op_write_reg) begin
            dload_next = ramload;
          end
        end else if (ram_fail) begin
          state_next = DONE;
          err_next   = 1'b1;
          if (state_reg == SERVE_I) begin
            iload_next = '0;
          end else if (!op_write_reg) begin
            dload_next = '0;
          end
        end else if (!still_requested) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output decodes from flops only, so nothing here is combinational from inputs.
  assign ramREN   = (state_reg == SERVE_I) || ((state_reg == SERVE_D) && !op_write_reg);
  assign ramWEN   = (state_reg == SERVE_D) && op_write_reg;
  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;
  assign dhit     = (state_reg == DONE) && from_d_reg;
  assign ihit     = (state_reg == DONE) && !from_d_reg;
  assign memerr   = (state_reg == DONE) && err_reg;
  assign iload    = iload_reg;
  assign dload    = dload_reg;

endmodule
